// File: rtl/aprx_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one approximate FP multiplier between two
// requesters: accept one op, launch operands, wait LAT cycles, return the result.
module aprx_mul_arbiter #(
    parameter int LAT   = 1,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_mode,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [15:0] resp_data,
    output logic        resp_mode,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_mode,
    input  logic [15:0] mul_c16,
    input  logic [7:0]  mul_c8,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_mode;

    // On contention the port that did not win last time is granted.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
        req1_ready = !rst && (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_a      = grant ? req1_a    : req0_a;
        sel_b      = grant ? req1_b    : req0_b;
        sel_mode   = grant ? req1_mode : req0_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_mode    <= 1'b0;
            resp_data   <= '0;
            resp_mode   <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a      <= sel_a;
                        mul_b      <= sel_b;
                        mul_mode   <= sel_mode;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= LAT_C;
                        state      <= HOLD;
                        busy       <= 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= cnt - ONE;
                    // Last settle cycle: the multiplier output is valid on this edge.
                    if (cnt == ONE) begin
                        resp_data   <= mul_mode ? {8'h00, mul_c8} : mul_c16;
                        resp_mode   <= mul_mode;
                        resp0_valid <= !owner;
                        resp1_valid <= owner;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aprx_mul_arbiter.sv
// Scoreboard bench for aprx_mul_arbiter: transaction-level model predicts grants,
// response timing and result data; a per-cycle monitor compares the DUT against it.
module tb_aprx_mul_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_mode = 1'b0, req1_mode = 1'b0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_mode;
    logic [31:0] mul_a, mul_b;
    logic        mul_mode;
    logic [15:0] mul_c16;
    logic [7:0]  mul_c8;
    logic        busy;

    assign mul_c16 = mul_a[31:16];
    assign mul_c8  = mul_b[31:24];

    aprx_mul_arbiter #(.LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_mode(resp_mode),
        .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode),
        .mul_c16(mul_c16), .mul_c8(mul_c8), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] b; logic mode;} tx_t;
    typedef struct {logic port; logic [15:0] data; logic mode; int due;} exp_t;

    tx_t  q0[$], q1[$];
    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   rr0 = 100, rr1 = 100;
    bit   noise = 0, drop_en = 0;
    logic rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge <= rst;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: each port holds its current transaction until the handshake is seen.
    initial begin : driver
        tx_t c0, c1;
        bit  v0 = 0, v1 = 0, acc0, acc1;
        forever begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) v0 = 0;
            if (acc1) v1 = 0;
            if (drop_en && v0 && ($urandom_range(7) == 0)) v0 = 0;
            if (drop_en && v1 && ($urandom_range(7) == 0)) v1 = 0;
            if (!v0 && q0.size() > 0) begin c0 = q0.pop_front(); v0 = 1; end
            if (!v1 && q1.size() > 0) begin c1 = q1.pop_front(); v1 = 1; end
            req0_valid = v0 ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            req1_valid = v1 ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            req0_a = v0 ? c0.a : $urandom;  req0_b = v0 ? c0.b : $urandom;
            req0_mode = v0 ? c0.mode : 1'($urandom);
            req1_a = v1 ? c1.a : $urandom;  req1_b = v1 ? c1.b : $urandom;
            req1_mode = v1 ? c1.mode : 1'($urandom);
            resp0_ready = ($urandom_range(99) < rr0);
            resp1_ready = ($urandom_range(99) < rr1);
        end
    end

    // Monitor with transaction-level reference model.
    initial begin : monitor
        int          cyc = 0;
        bit          started = 0, m_free = 1, m_last = 1, rel, win, any;
        logic [31:0] m_a = '0, m_b = '0, wa, wb;
        logic        m_mode = 1'b0, wm;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_at_edge) begin
                started = 1; sb.delete(); m_free = 1; m_last = 1;
                m_a = '0; m_b = '0; m_mode = 1'b0;
                chk("reset_outputs", {mul_a, mul_b, mul_mode, resp_data, resp_mode,
                                      resp0_valid, resp1_valid, busy}, '0);
            end
            if (started) begin
                rel = 0;
                chk("mul_operands", {mul_a, mul_b, mul_mode}, {m_a, m_b, m_mode});
                if (sb.size() > 0 && cyc >= sb[0].due) begin
                    chk("resp_valids", {resp1_valid, resp0_valid}, {sb[0].port, !sb[0].port});
                    chk("resp_data", resp_data, sb[0].data);
                    chk("resp_mode", resp_mode, sb[0].mode);
                    if (sb[0].port ? resp1_ready : resp0_ready) begin
                        void'(sb.pop_front());
                        rel = 1;
                    end
                end else begin
                    chk("resp_idle", {resp1_valid, resp0_valid}, 2'b00);
                end
                chk("busy", busy, !m_free);
                any = req0_valid || req1_valid;
                win = (req0_valid && req1_valid) ? !m_last : req1_valid;
                if (!rst && m_free && any) begin
                    chk("req_ready", {req1_ready, req0_ready}, {win, !win});
                    wa = win ? req1_a : req0_a;
                    wb = win ? req1_b : req0_b;
                    wm = win ? req1_mode : req0_mode;
                    e.port = win;
                    e.data = wm ? {8'h00, wb[31:24]} : wa[31:16];
                    e.mode = wm;
                    e.due  = cyc + LAT + 1;
                    sb.push_back(e);
                    m_last = win; m_free = 0;
                    m_a = wa; m_b = wb; m_mode = wm;
                end else begin
                    chk("req_ready_low", {req1_ready, req0_ready}, 2'b00);
                end
                if (rel) m_free = 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        noise = 1;
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        noise = 0;
        #1 rst = 1'b0;
    endtask

    function automatic tx_t mk(input logic [31:0] a, input logic [31:0] b, input logic mode);
        tx_t t;
        t.a = a; t.b = b; t.mode = mode;
        return t;
    endfunction

    initial begin : main
        bit seen;
        do_reset(2);
        idle(2);
        // Single op on port 0
        @(posedge clk);
        q0.push_back(mk(32'h3F800000, 32'h40000000, 1'b0));
        idle(10);
        // Contention right after reset: port 0 first, port 1 in binary8
        do_reset(1);
        @(posedge clk);
        q0.push_back(mk($urandom, $urandom, 1'b0));
        q1.push_back(mk($urandom, 32'hC0400000, 1'b1));
        idle(15);
        // Fairness with both ports continuously requesting
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk($urandom, $urandom, 1'($urandom)));
            q1.push_back(mk($urandom, $urandom, 1'($urandom)));
        end
        idle(30);
        // Backpressure on port 0 followed by a single-cycle ready pulse
        @(posedge clk);
        rr0 = 0;
        q0.push_back(mk($urandom, $urandom, 1'b1));
        q1.push_back(mk($urandom, $urandom, 1'b0));
        idle(LAT + 8);
        rr0 = 100;
        @(posedge clk);
        rr0 = 0;
        idle(20);
        rr0 = 100;
        idle(5);
        // Reset during HOLD aborts the op; contention afterwards favours port 0
        @(posedge clk);
        q0.push_back(mk(32'h12345678, 32'h9ABCDEF0, 1'b0));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_reset_accept: got no accept expected accept within 20 cycles");
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        @(posedge clk);
        q0.push_back(mk($urandom, $urandom, 1'($urandom)));
        q1.push_back(mk($urandom, $urandom, 1'($urandom)));
        idle(20);
        // Random traffic with dropped requests and random response backpressure
        drop_en = 1; rr0 = 70; rr1 = 60;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (q0.size() < 2 && $urandom_range(3) == 0) q0.push_back(mk($urandom, $urandom, 1'($urandom)));
            if (q1.size() < 2 && $urandom_range(3) == 0) q1.push_back(mk($urandom, $urandom, 1'($urandom)));
            if (i == 300) do_reset(1);
        end
        drop_en = 0; rr0 = 100; rr1 = 100;
        idle(60);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aprx_mul_arbiter.md
Name: aprx_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one approximate FP multiplier datapath (32-bit operands in, binary16-alt `c16` / binary8 `c8` out, `mode` select) between two requesters. It accepts one operation at a time over valid/ready, drives registered operands to the multiplier and waits a fixed settle latency. It then captures the result and returns it to the owning requester over a valid/ready response channel. It sits between the multiplier and the two client datapaths.

Parameters:
LAT, 1, multiplier settle cycles between operand launch and result capture; legal range 1..15
CNT_W, 4, width of settle counter; must hold LAT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  port 0 operation request
req0_ready  out  1  port 0 accept
req0_a  in  32  port 0 operand A
req0_b  in  32  port 0 operand B
req0_mode  in  1  port 0 format: 0=binary16 alt, 1=binary8
req1_valid, req1_ready, req1_a, req1_b, req1_mode  same as port 0, for port 1
resp0_valid  out  1  result valid for port 0
resp0_ready  in  1  port 0 result accept
resp1_valid  out  1  result valid for port 1
resp1_ready  in  1  port 1 result accept
resp_data  out  16  result, shared by both response ports
resp_mode  out  1  mode of the returned result
mul_a  out  32  operand A to multiplier
mul_b  out  32  operand B to multiplier
mul_mode  out  1  mode to multiplier
mul_c16  in  16  multiplier binary16 result
mul_c8  in  8  multiplier binary8 result
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, HOLD, RESP. Reset puts the FSM in IDLE with counter 0 and last_grant=1, so port 0 wins the first contention.
- Reset values: all outputs 0, including mul_a, mul_b, mul_mode, resp_data, resp_mode, resp*_valid and busy.
- IDLE grant selection:
  - Only req0_valid high: grant port 0.
  - Only req1_valid high: grant port 1.
  - Both high: grant the port != last_grant.
  - req*_ready is combinational and high only for the granted port, only in IDLE. The ungranted port's ready stays 0.
- Accept (valid&ready at edge T):
  - Latch a, b and mode into the mul_* registers and latch owner.
  - Set last_grant=owner, load counter=LAT and go to HOLD.
  - mul_* registers hold stable until the next accept.
- HOLD:
  - Counter decrements each cycle, so HOLD lasts exactly LAT cycles (T+1 .. T+LAT).
  - On the edge ending cycle T+LAT, capture resp_data: {mul_c16} if mode=0, {8'h00, mul_c8} if mode=1. Capture resp_mode=mode and go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid=0. resp_valid first rises in cycle T+LAT+1.
  - resp_data and resp_mode stay stable while valid && !ready.
  - On resp<owner>_valid && resp<owner>_ready, go to IDLE and clear valid. The next accept is possible the following cycle.
- Throughput: one operation per LAT+2 cycles minimum; only one operation in flight.
- No request is accepted in HOLD or RESP; req*_ready=0 there.
- A requester may drop valid before acceptance; it is not latched.
- Reset mid-operation (any state): the operation is aborted with no response, all outputs return to reset values next cycle, and last_grant returns to 1.
- resp*_ready is ignored outside RESP.

Test Plan:
Bench multiplier model for all tests: mul_c16 = mul_a[31:16], mul_c8 = mul_b[31:24].

1. Reset: rst high 2 cycles with random inputs -> all outputs 0, busy=0, both req*_ready=0 when no valid.
2. Single op, LAT=2: req0 a=32'h3F800000, b=32'h40000000, mode=0, accepted cycle 0 -> mul_a=32'h3F800000 from cycle 1; resp0_valid rises cycle 3 with resp_data=16'h3F80, resp_mode=0; resp1_valid stays 0.
3. Contention: req0 and req1 valid together after reset; req1 b=32'hC0400000, mode=1 -> port 0 served first, then port 1. Port 1 result: resp_data=16'h00C0, resp_mode=1, on resp1_valid only.
4. Fairness: both ports held valid for 4 operations -> grant order 0,1,0,1; each accept spaced exactly LAT+2 cycles with resp*_ready tied high.
5. Backpressure: resp0_ready low 5 cycles in RESP -> resp0_valid, resp_data and resp_mode stable; req0_ready and req1_ready stay 0. The single-cycle ready pulse completes the handshake, and IDLE follows next cycle.
6. Reset in HOLD (cycle T+1, LAT=3) -> next cycle IDLE, no resp*_valid ever seen for that op, mul_a=0. Afterwards, simultaneous requests grant port 0 first.
